mem_16_8: RTL and testbench
===========================

MEM_16_8 -- requirements
Module: mem_16_8

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 8, setting the data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, setting the address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 16 (2**ADDR_W), setting the number of storage words.

Interface
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port wren, input, 1 bit: write enable.
REQ-008 The block SHALL have port wr_addr, input, ADDR_W bits: write address.
REQ-009 The block SHALL have port wr_data, input, DATA_W bits: write data.
REQ-010 The block SHALL have port rden, input, 1 bit: read enable.
REQ-011 The block SHALL have port rd_addr, input, ADDR_W bits: read address.
REQ-012 The block SHALL have port rd_data, output, DATA_W bits: registered read data.
REQ-013 The block SHALL have port ovalid, output, 1 bit: read-data-valid strobe.

Function
REQ-014 The block SHALL contain DEPTH words of DATA_W bits, organised as a simple dual-port memory with independent write and read ports.
REQ-015 On each rising clk edge with wren=1, the block SHALL store wr_data into word wr_addr.
REQ-016 When wren=0, the block SHALL leave memory contents unchanged.
REQ-017 On each rising clk edge with rden=1, the block SHALL load rd_data with word rd_addr, giving one cycle of latency from the sampled request.
REQ-018 On each rising clk edge with rden=1, the block SHALL set ovalid=1.
REQ-019 On each rising clk edge with rden=0, the block SHALL clear ovalid=0 and hold rd_data at its previous value.
REQ-020 ovalid SHALL assert for exactly one cycle per sampled rden=1 cycle; back-to-back reads SHALL keep ovalid high continuously and update rd_data every cycle.
REQ-021 On a simultaneous write and read of the same address in one edge (read-during-write), rd_data SHALL return the old stored word; the new word SHALL be readable from the following edge.
REQ-022 Simultaneous write and read of different addresses SHALL both complete in the same cycle with no interaction.
REQ-023 Addresses SHALL be fully decoded; with DEPTH=2**ADDR_W every address is valid and no wrap or range check applies.
REQ-024 The block SHALL have no handshake back-pressure; a request is accepted every cycle.

Reset
REQ-025 While rst_n=0, asynchronously and independent of clk, the block SHALL force rd_data=0, ovalid=0 and all memory words to 0.
REQ-026 A write or read sampled while rst_n=0 SHALL be ignored.
REQ-027 Reset asserted mid-operation SHALL discard any pending read result, so ovalid=0 on the first edge after release unless rden=1 at that edge.
REQ-028 After rst_n deasserts, normal operation SHALL begin at the first rising clk edge.

Verification
REQ-029 The bench SHALL cover: write 8'd10 to address 0, then rden=1 at address 0 two cycles later -> next edge rd_data=8'b00001010 and ovalid=1; rden=0 on the following edge -> ovalid=0 with rd_data held at 8'd10.
REQ-030 The bench SHALL cover: write address i with value 8'hA0+i for i=0..15, then read 0..15 back-to-back -> rd_data=8'hA0+i one cycle after each request, with ovalid high for 16 consecutive cycles.
REQ-031 The bench SHALL cover: address 3 holds 8'h11; write 8'h22 to address 3 and read address 3 in the same cycle -> rd_data=8'h11; read again next cycle -> rd_data=8'h22.
REQ-032 The bench SHALL cover: write 8'hFF to address 5 and read address 9 in the same cycle -> rd_data=0 (reset value of address 9); a later read of address 5 -> rd_data=8'hFF.
REQ-033 The bench SHALL cover: rst_n pulled low between clock edges during a read burst -> rd_data=0 and ovalid=0 immediately; after release, reading address 0 -> rd_data=0.
REQ-034 The bench SHALL cover: wren=0 with wr_data=8'h55 at address 7 -> a later read of address 7 returns 0.

Source files
------------

// File: rtl/mem_16_8.sv
// Simple dual-port register-file memory: one synchronous write port, one registered read port
// with a one-cycle valid strobe. Asynchronous reset clears storage and read outputs.
module mem_16_8 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wren,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rden,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              ovalid
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;
    logic              r_ovalid;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_rd_data_nxt;

    // Storage array: cleared on reset, written on wren.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wren) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read mux sees the pre-edge array, so read-during-write returns the old word.
    always_comb begin
        w_rd_word = r_mem[rd_addr];
        if (rden) begin
            w_rd_data_nxt = w_rd_word;
        end else begin
            w_rd_data_nxt = r_rd_data;
        end
    end

    // Registered read data and valid strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
            r_ovalid  <= 1'b0;
        end else begin
            r_rd_data <= w_rd_data_nxt;
            r_ovalid  <= rden;
        end
    end

    assign rd_data = r_rd_data;
    assign ovalid  = r_ovalid;

endmodule

// File: tb/tb_mem_16_8.sv
// Directed self-checking bench for mem_16_8: hand-computed expected values checked with
// immediate assertions roughly 1 time unit after each rising clock edge.
module tb_mem_16_8;

    logic       clk;
    logic       rst_n;
    logic       wren;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       rden;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       ovalid;

    int n_cmp;
    int n_bad;

    mem_16_8 #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wren    (wren),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rden    (rden),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .ovalid  (ovalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        wren    = 1'b0;
        wr_addr = 4'd0;
        wr_data = 8'd0;
        rden    = 1'b0;
        rd_addr = 4'd0;

        tick();
        tick();
        check("reset_rd_data", {24'd0, rd_data}, 32'h0);
        check("reset_ovalid", {31'd0, ovalid}, 32'h0);
        rst_n = 1'b1;

        // Write 10 to addr 0, idle, read addr 0, then idle.
        wren = 1'b1; wr_addr = 4'd0; wr_data = 8'd10;
        tick();
        wren = 1'b0;
        tick();
        check("idle_ovalid", {31'd0, ovalid}, 32'h0);
        rden = 1'b1; rd_addr = 4'd0;
        tick();
        check("rd0_data", {24'd0, rd_data}, 32'h0A);
        check("rd0_valid", {31'd0, ovalid}, 32'h1);
        rden = 1'b0;
        tick();
        check("hold_valid", {31'd0, ovalid}, 32'h0);
        check("hold_data", {24'd0, rd_data}, 32'h0A);

        // wren=0 must not write addr 7.
        wren = 1'b0; wr_addr = 4'd7; wr_data = 8'h55;
        tick();
        rden = 1'b1; rd_addr = 4'd7;
        tick();
        check("nowr7_data", {24'd0, rd_data}, 32'h00);
        check("nowr7_valid", {31'd0, ovalid}, 32'h1);
        rden = 1'b0;

        // Write addr 5 while reading addr 9 in the same cycle.
        wren = 1'b1; wr_addr = 4'd5; wr_data = 8'hFF;
        rden = 1'b1; rd_addr = 4'd9;
        tick();
        check("diff_rd9", {24'd0, rd_data}, 32'h00);
        wren = 1'b0; rden = 1'b0;
        tick();
        rden = 1'b1; rd_addr = 4'd5;
        tick();
        check("diff_rd5", {24'd0, rd_data}, 32'hFF);
        rden = 1'b0;

        // Read-during-write on addr 3 returns old word, new word next cycle.
        wren = 1'b1; wr_addr = 4'd3; wr_data = 8'h11;
        tick();
        wren = 1'b1; wr_addr = 4'd3; wr_data = 8'h22;
        rden = 1'b1; rd_addr = 4'd3;
        tick();
        check("rdw_old", {24'd0, rd_data}, 32'h11);
        wren = 1'b0;
        tick();
        check("rdw_new", {24'd0, rd_data}, 32'h22);
        check("rdw_valid", {31'd0, ovalid}, 32'h1);
        rden = 1'b0;

        // Fill all addresses, then read back-to-back.
        wren = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_addr = 4'(i);
            wr_data = 8'(8'hA0 + i);
            tick();
        end
        wren = 1'b0;
        rden = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            tick();
            check($sformatf("burst_data_%0d", i), {24'd0, rd_data}, 32'(8'hA0 + i));
            check($sformatf("burst_valid_%0d", i), {31'd0, ovalid}, 32'h1);
        end
        rden = 1'b0;
        tick();
        check("burst_end_valid", {31'd0, ovalid}, 32'h0);
        check("burst_end_hold", {24'd0, rd_data}, 32'hAF);

        // Reset mid-burst between edges; a write during reset is ignored.
        rden = 1'b1; rd_addr = 4'd4;
        tick();
        check("pre_rst_data", {24'd0, rd_data}, 32'hA4);
        rd_addr = 4'd6;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_data", {24'd0, rd_data}, 32'h00);
        check("async_rst_valid", {31'd0, ovalid}, 32'h0);
        wren = 1'b1; wr_addr = 4'd2; wr_data = 8'h77;
        tick();
        check("in_rst_valid", {31'd0, ovalid}, 32'h0);
        check("in_rst_data", {24'd0, rd_data}, 32'h00);
        wren = 1'b0; rden = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", {31'd0, ovalid}, 32'h0);
        rden = 1'b1; rd_addr = 4'd0;
        tick();
        check("post_rst_rd0", {24'd0, rd_data}, 32'h00);
        check("post_rst_rd0_valid", {31'd0, ovalid}, 32'h1);
        rd_addr = 4'd2;
        tick();
        check("post_rst_rd2", {24'd0, rd_data}, 32'h00);
        rd_addr = 4'd5;
        tick();
        check("post_rst_rd5", {24'd0, rd_data}, 32'h00);
        rden = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
